// File: rtl/control_fsm_pkg.sv
// Shared opcode, ALU function and state encodings for the multi-cycle control unit.
package control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH
  } state_t;

endpackage

// File: rtl/control_fsm_opcode_class.sv
// Combinational opcode classifier: maps a 6-bit opcode onto the class bits the FSM sequences on.
module opcode_class
  import control_fsm_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_rtype,
  output logic       is_imm,
  output logic       is_load,
  output logic       is_store,
  output logic       is_byte,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_illegal
);

  always_comb begin
    is_rtype   = 1'b0;
    is_imm     = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_byte    = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_RTYPE:                               is_rtype  = 1'b1;
      OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI: is_imm    = 1'b1;
      OP_B:                                   is_jump   = 1'b1;
      OP_BEQ, OP_BNE:                         is_branch = 1'b1;
      OP_LB: begin
        is_load = 1'b1;
        is_byte = 1'b1;
      end
      OP_LW:                                  is_load   = 1'b1;
      OP_SB: begin
        is_store = 1'b1;
        is_byte  = 1'b1;
      end
      OP_SW:                                  is_store  = 1'b1;
      default:                                is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/write-back and counts retired instructions.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instr,
  input  logic             Zero,
  input  logic             MEM_Ack,
  output logic             IR_LdEn,
  output logic             PC_LdEn,
  output logic             PC_sel,
  output logic             RF_WrEn,
  output logic             RF_WrData_sel,
  output logic             RF_B_sel,
  output logic             ALU_Bin_sel,
  output logic [3:0]       ALU_func,
  output logic             MEM_Req,
  output logic             MEM_WrEn,
  output logic             ByteOp,
  output logic             Illegal,
  output logic [CNT_W-1:0] Retired
);

  state_t     state;
  logic [5:0] op_q;
  logic [3:0] func_q;
  logic [5:0] cls_op;
  logic       is_rtype, is_imm, is_load, is_store, is_byte, is_branch, is_jump, is_illegal;
  logic       taken;
  logic       retire;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^Instr[25:4];

  // DECODE classifies the live IR; later states use the opcode latched on leaving DECODE.
  assign cls_op = (state == S_DECODE) ? Instr[31:26] : op_q;

  opcode_class u_opcode_class (
    .opcode    (cls_op),
    .is_rtype  (is_rtype),
    .is_imm    (is_imm),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_byte   (is_byte),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .is_illegal(is_illegal)
  );

  assign taken  = (op_q == OP_BEQ) ? Zero : !Zero;
  assign retire = ((state == S_DECODE) && is_jump)
               || ((state == S_MEM) && MEM_Ack && is_store)
               || (state == S_WB_ALU)
               || (state == S_WB_MEM)
               || (state == S_BRANCH);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_RST;
      op_q    <= '0;
      func_q  <= '0;
      Retired <= '0;
    end else begin
      case (state)
        S_RST:   state <= S_FETCH;
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          op_q   <= Instr[31:26];
          func_q <= Instr[3:0];
          if (is_jump || is_illegal) state <= S_FETCH;
          else if (is_branch)        state <= S_BRANCH;
          else                       state <= S_EXEC;
        end
        S_EXEC: state <= (is_load || is_store) ? S_MEM : S_WB_ALU;
        S_MEM: begin
          if (MEM_Ack) state <= is_load ? S_WB_MEM : S_FETCH;
        end
        S_WB_ALU, S_WB_MEM, S_BRANCH: state <= S_FETCH;
        default: state <= S_RST;
      endcase
      if (retire) Retired <= Retired + CNT_W'(1);
    end
  end

  // Reset in flight suppresses every strobe in the same cycle, so an aborted MEM wait issues nothing.
  always_comb begin
    IR_LdEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_ADD;
    MEM_Req       = 1'b0;
    MEM_WrEn      = 1'b0;
    ByteOp        = 1'b0;
    Illegal       = 1'b0;
    if (!Reset) begin
      case (state)
        S_FETCH: IR_LdEn = 1'b1;
        S_DECODE: begin
          RF_B_sel = is_store || is_branch;
          if (is_jump) begin
            PC_LdEn = 1'b1;
            PC_sel  = 1'b1;
          end
          if (is_illegal) begin
            Illegal = 1'b1;
            PC_LdEn = 1'b1;
          end
        end
        S_EXEC: begin
          RF_B_sel    = is_store;
          ALU_Bin_sel = !is_rtype;
          if (is_rtype)              ALU_func = func_q;
          else if (op_q == OP_ANDI)  ALU_func = ALU_AND;
          else if (op_q == OP_ORI)   ALU_func = ALU_OR;
          else                       ALU_func = ALU_ADD;
        end
        S_MEM: begin
          MEM_Req  = 1'b1;
          MEM_WrEn = is_store;
          ByteOp   = is_byte;
          RF_B_sel = is_store;
          PC_LdEn  = MEM_Ack && is_store;
        end
        S_WB_ALU: begin
          RF_WrEn = 1'b1;
          PC_LdEn = 1'b1;
        end
        S_WB_MEM: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = 1'b1;
          PC_LdEn       = 1'b1;
        end
        S_BRANCH: begin
          ALU_func = ALU_SUB;
          RF_B_sel = 1'b1;
          PC_LdEn  = 1'b1;
          PC_sel   = taken;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Instruction-level bench: each instruction expands to its expected per-cycle control pattern.
module tb_control_fsm;

  localparam logic [5:0] T_R    = 6'b100000;
  localparam logic [5:0] T_LI   = 6'b111000;
  localparam logic [5:0] T_LUI  = 6'b111001;
  localparam logic [5:0] T_ADDI = 6'b110000;
  localparam logic [5:0] T_ANDI = 6'b110010;
  localparam logic [5:0] T_ORI  = 6'b110011;
  localparam logic [5:0] T_B    = 6'b111111;
  localparam logic [5:0] T_BEQ  = 6'b000000;
  localparam logic [5:0] T_BNE  = 6'b000001;
  localparam logic [5:0] T_LB   = 6'b000011;
  localparam logic [5:0] T_LW   = 6'b001111;
  localparam logic [5:0] T_SB   = 6'b000111;
  localparam logic [5:0] T_SW   = 6'b011111;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BEQ = 3, K_BNE = 4, K_B = 5, K_ILL = 6;

  typedef struct packed {
    logic       ir, pcl, pcs, rfw, rfd, rbs, abs;
    logic [3:0] fn;
    logic       mr, mw, bo, il;
  } ov_t;

  logic        Clk, Reset, Zero, MEM_Ack;
  logic [31:0] Instr;
  logic        IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        MEM_Req, MEM_WrEn, ByteOp, Illegal;
  logic [31:0] Retired;
  ov_t         obs;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  control_fsm #(.CNT_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .MEM_Ack(MEM_Ack),
    .IR_LdEn(IR_LdEn), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .MEM_Req(MEM_Req), .MEM_WrEn(MEM_WrEn), .ByteOp(ByteOp),
    .Illegal(Illegal), .Retired(Retired)
  );

  assign obs = '{ir: IR_LdEn, pcl: PC_LdEn, pcs: PC_sel, rfw: RF_WrEn, rfd: RF_WrData_sel,
                 rbs: RF_B_sel, abs: ALU_Bin_sel, fn: ALU_func, mr: MEM_Req, mw: MEM_WrEn,
                 bo: ByteOp, il: Illegal};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op);
    case (op)
      T_R, T_LI, T_LUI, T_ADDI, T_ANDI, T_ORI: return K_ALU;
      T_LB, T_LW: return K_LOAD;
      T_SB, T_SW: return K_STORE;
      T_BEQ:      return K_BEQ;
      T_BNE:      return K_BNE;
      T_B:        return K_B;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic rand_bit();
    return 1'(($urandom >> 7) & 1);
  endfunction

  // One clock cycle: drive at posedge+1, compare at the following negedge, return at next posedge+1.
  task automatic cyc(input logic [31:0] ins, input logic ack, input logic z, input logic rst,
                     input ov_t e, input string tag);
    Instr = ins; MEM_Ack = ack; Zero = z; Reset = rst;
    #4;
    check(tag, 32'(obs), 32'(e));
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    ov_t e;
    e = '0;
    for (int i = 0; i < n; i++) cyc($urandom, rand_bit(), rand_bit(), 1'b1, e, "reset_outs");
    check("reset_retired", Retired, 32'd0);
    exp_ret = 0;
    cyc($urandom, rand_bit(), rand_bit(), 1'b0, e, "rst_state_outs");
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [3:0] func, input int waits,
                           input logic z);
    logic [31:0] ins;
    int          k;
    logic        st, byt;
    ov_t         e;
    ins       = $urandom;
    ins[31:26] = op;
    ins[3:0]   = func;
    k   = classify(op);
    st  = (k == K_STORE);
    byt = (op == T_LB) || (op == T_SB);

    e = '0; e.ir = 1'b1;
    cyc($urandom, rand_bit(), rand_bit(), 1'b0, e, "fetch");

    e = '0;
    e.rbs = st || (k == K_BEQ) || (k == K_BNE);
    if (k == K_B)   begin e.pcl = 1'b1; e.pcs = 1'b1; end
    if (k == K_ILL) begin e.pcl = 1'b1; e.il = 1'b1; end
    cyc(ins, rand_bit(), rand_bit(), 1'b0, e, "decode");

    if (k == K_B) begin
      exp_ret++;
    end else if (k == K_BEQ || k == K_BNE) begin
      e = '0; e.rbs = 1'b1; e.fn = 4'b0001; e.pcl = 1'b1;
      e.pcs = (k == K_BEQ) ? z : !z;
      cyc(ins, rand_bit(), z, 1'b0, e, "branch");
      exp_ret++;
    end else if (k != K_ILL) begin
      e = '0; e.rbs = st; e.abs = (op != T_R);
      e.fn = (op == T_R) ? func : (op == T_ANDI) ? 4'b0010 : (op == T_ORI) ? 4'b0011 : 4'b0000;
      cyc(ins, rand_bit(), rand_bit(), 1'b0, e, "exec");
      if (k == K_ALU) begin
        e = '0; e.rfw = 1'b1; e.pcl = 1'b1;
        cyc(ins, rand_bit(), rand_bit(), 1'b0, e, "wb_alu");
        exp_ret++;
      end else begin
        for (int w = 0; w <= waits; w++) begin
          e = '0; e.mr = 1'b1; e.mw = st; e.bo = byt; e.rbs = st;
          e.pcl = st && (w == waits);
          cyc(ins, (w == waits), rand_bit(), 1'b0, e, "mem");
        end
        if (k == K_STORE) exp_ret++;
        else begin
          e = '0; e.rfw = 1'b1; e.rfd = 1'b1; e.pcl = 1'b1;
          cyc(ins, rand_bit(), rand_bit(), 1'b0, e, "wb_mem");
          exp_ret++;
        end
      end
    end
    check("retired", Retired, 32'(exp_ret));
  endtask

  // lw stalled in MEM, then Reset arrives mid-wait.
  task automatic reset_in_mem();
    logic [31:0] ins;
    ov_t         e;
    ins = $urandom;
    ins[31:26] = T_LW;
    e = '0; e.ir = 1'b1;
    cyc($urandom, 1'b1, 1'b0, 1'b0, e, "rm_fetch");
    e = '0;
    cyc(ins, 1'b1, 1'b0, 1'b0, e, "rm_decode");
    e = '0; e.abs = 1'b1;
    cyc(ins, 1'b1, 1'b0, 1'b0, e, "rm_exec");
    e = '0; e.mr = 1'b1;
    cyc(ins, 1'b0, 1'b0, 1'b0, e, "rm_mem_wait");
    e = '0;
    cyc(ins, 1'b1, 1'b0, 1'b1, e, "rm_reset_cycle");
    check("rm_retired", Retired, 32'd0);
    exp_ret = 0;
    cyc(ins, 1'b1, 1'b0, 1'b0, e, "rm_rst_state");
  endtask

  logic [5:0] legal_ops [13];

  initial begin
    logic [5:0] op;
    int         idx;
    legal_ops = '{T_R, T_LI, T_LUI, T_ADDI, T_ANDI, T_ORI, T_B, T_BEQ, T_BNE,
                  T_LB, T_LW, T_SB, T_SW};
    Reset = 1'b1; Instr = '0; Zero = 1'b0; MEM_Ack = 1'b0;
    @(posedge Clk);
    #1;

    do_reset(3);
    run_instr(T_R, 4'b0000, 0, 1'b0);
    run_instr(T_LW, 4'd0, 2, 1'b0);
    run_instr(T_SB, 4'd0, 0, 1'b0);
    run_instr(T_BEQ, 4'd0, 0, 1'b1);
    run_instr(T_BNE, 4'd0, 0, 1'b1);
    run_instr(6'b010101, 4'd0, 0, 1'b0);
    run_instr(T_B, 4'd0, 0, 1'b0);
    reset_in_mem();
    run_instr(T_ANDI, 4'd0, 0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      idx = $urandom_range(0, 14);
      if (idx < 13) op = legal_ops[idx];
      else          op = 6'($urandom_range(0, 63));
      run_instr(op, 4'($urandom_range(0, 3)), $urandom_range(0, 3), rand_bit());
    end

    do_reset(1);
    run_instr(T_SW, 4'd0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
